bip_run_control: RTL and testbench

Run/step/halt sequencer for the BIP core. It turns the board `start` switch into a clean program launch, gates the core's PC and accumulator updates, and stops execution on the HLT opcode. It also counts executed cycles and freezes an accumulator snapshot for the LEDs. It sits in TOP between the board inputs and the core datapath, replacing free-running execution.

---
 rtl/bip_run_control_if.sv | 25 ++
 rtl/bip_run_control.sv | 115 +++++++++++
 tb/tb_bip_run_control.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bip_run_control_if.sv
// Core-side bundle of the BIP run/step/halt sequencer.
// master: sequencer (drives core_en/core_clear, reads instr_opcode/acc_in); slave: core datapath.
interface bip_run_control_if #(
    parameter int DATA_W   = 16,
    parameter int OPCODE_W = 5
);
    logic                core_en;
    logic                core_clear;
    logic [OPCODE_W-1:0] instr_opcode;
    logic [DATA_W-1:0]   acc_in;

    modport master (
        output core_en,
        output core_clear,
        input  instr_opcode,
        input  acc_in
    );

    modport slave (
        input  core_en,
        input  core_clear,
        output instr_opcode,
        output acc_in
    );
endinterface

// File: rtl/bip_run_control.sv
// Run/step/halt sequencer for the BIP core: launches on start edge, gates PC/ACC, stops on HLT.
// Ports: clk, reset (sync, high), start/step_mode/step, core bundle, running/halted, clk_count, acc_snapshot, led_acc.
module bip_run_control #(
    parameter int                  DATA_W     = 16,
    parameter int                  OPCODE_W   = 5,
    parameter int                  COUNT_W    = 8,
    parameter logic [OPCODE_W-1:0] HLT_OPCODE = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               step_mode,
    input  logic               step,
    bip_run_control_if.master  core,
    output logic               running,
    output logic               halted,
    output logic [COUNT_W-1:0] clk_count,
    output logic [DATA_W-1:0]  acc_snapshot,
    output logic [7:0]         led_acc
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        STEP,
        HALTED
    } state_t;

    localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

    state_t state_q;
    state_t state_d;
    logic   start_q;
    logic   step_q;
    logic   start_rise;
    logic   step_rise;
    logic   hlt_hit;
    logic   snap_en;

    // Edge history resets high so a switch already up at reset does not launch.
    assign start_rise = start & ~start_q;
    assign step_rise  = step & ~step_q;
    assign hlt_hit    = (core.instr_opcode == HLT_OPCODE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            start_q      <= 1'b1;
            step_q       <= 1'b1;
            clk_count    <= '0;
            acc_snapshot <= '0;
        end else begin
            state_q <= state_d;
            start_q <= start;
            step_q  <= step;
            if (core.core_clear) begin
                clk_count <= '0;
            end else if (core.core_en && (clk_count != COUNT_MAX)) begin
                clk_count <= clk_count + 1'b1;
            end
            if (snap_en) begin
                acc_snapshot <= core.acc_in;
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        core.core_en    = 1'b0;
        core.core_clear = 1'b0;
        snap_en         = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_rise) begin
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                core.core_clear = 1'b1;
                state_d         = step_mode ? STEP : RUN;
            end
            RUN: begin
                // HLT is decoded before the PC can move past it.
                if (hlt_hit) begin
                    snap_en = 1'b1;
                    state_d = HALTED;
                end else begin
                    core.core_en = 1'b1;
                end
            end
            STEP: begin
                if (hlt_hit) begin
                    snap_en = 1'b1;
                    state_d = HALTED;
                end else if (step_rise) begin
                    core.core_en = 1'b1;
                end
            end
            HALTED: begin
                if (start_rise) begin
                    state_d = CLEAR;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign running = (state_q == RUN) || (state_q == STEP);
    assign halted  = (state_q == HALTED);
    assign led_acc = acc_snapshot[7:0];

endmodule

// File: tb/tb_bip_run_control.sv
// Bench for bip_run_control: small BIP core model, program-level reference and halt scoreboard.
// Expected results are queued at launch and checked by a monitor when halted rises.
module tb_bip_run_control;

    localparam int DATA_W   = 16;
    localparam int OPCODE_W = 5;
    localparam int COUNT_W  = 8;
    localparam logic [4:0] OP_HLT  = 5'd0;
    localparam logic [4:0] OP_LDI  = 5'd3;
    localparam logic [4:0] OP_ADDI = 5'd5;

    typedef struct {
        logic [15:0] acc;
        int          cnt;
        int          en;
        int          run_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic step_mode;
    logic step;
    logic running;
    logic halted;
    logic [COUNT_W-1:0] clk_count;
    logic [DATA_W-1:0]  acc_snapshot;
    logic [7:0]         led_acc;

    bip_run_control_if #(.DATA_W(DATA_W), .OPCODE_W(OPCODE_W)) bus ();

    bip_run_control #(
        .DATA_W(DATA_W),
        .OPCODE_W(OPCODE_W),
        .COUNT_W(COUNT_W),
        .HLT_OPCODE(OP_HLT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .step_mode(step_mode),
        .step(step),
        .core(bus.master),
        .running(running),
        .halted(halted),
        .clk_count(clk_count),
        .acc_snapshot(acc_snapshot),
        .led_acc(led_acc)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural core: program ROM, PC and accumulator.
    logic [15:0] prog [0:511];
    logic [8:0]  pc  = '0;
    logic [15:0] acc = '0;

    assign bus.instr_opcode = prog[pc][15:11];
    assign bus.acc_in       = acc;

    always @(posedge clk) begin
        if (bus.core_clear) begin
            pc  <= '0;
            acc <= '0;
        end else if (bus.core_en) begin
            pc <= pc + 1'b1;
            case (prog[pc][15:11])
                OP_LDI:  acc <= {5'd0, prog[pc][10:0]};
                OP_ADDI: acc <= acc + {5'd0, prog[pc][10:0]};
                default: ;
            endcase
        end
    end

    // Reference: walk the program to its first HLT.
    function automatic exp_t model(input logic step_md);
        exp_t e;
        int n;
        logic [15:0] a;
        logic [15:0] w;
        n = 0;
        a = '0;
        w = prog[0];
        while (w[15:11] != OP_HLT) begin
            if (w[15:11] == OP_LDI) a = {5'd0, w[10:0]};
            else if (w[15:11] == OP_ADDI) a = a + {5'd0, w[10:0]};
            n++;
            w = prog[n];
        end
        e.acc     = a;
        e.cnt     = (n > 255) ? 255 : n;
        e.en      = n;
        e.run_cyc = step_md ? -1 : n + 1;
        return e;
    endfunction

    task automatic clear_prog();
        for (int i = 0; i < 512; i++) prog[i] = '0;
    endtask

    task automatic load_directed();
        clear_prog();
        prog[0] = {OP_LDI, 11'd5};
        prog[1] = {OP_ADDI, 11'd3};
        prog[2] = {OP_HLT, 11'd0};
    endtask

    task automatic load_long();
        clear_prog();
        for (int i = 0; i < 300; i++) prog[i] = {OP_ADDI, 11'd1};
    endtask

    task automatic load_random(input int n);
        clear_prog();
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) prog[i] = {OP_LDI, 11'($urandom)};
            else prog[i] = {OP_ADDI, 11'($urandom)};
        end
    endtask

    // Scoreboard and monitor.
    exp_t exp_q[$];
    int   en_cnt   = 0;
    int   en_total = 0;
    int   run_cyc  = 0;
    int   clr_run  = 0;
    int   clr_len  = 0;
    logic halted_q = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        check("en_clear_excl", bus.core_en & bus.core_clear, 0);
        if (bus.core_clear) begin
            clr_run++;
            en_cnt  = 0;
            run_cyc = 0;
        end else if (clr_run != 0) begin
            clr_len = clr_run;
            clr_run = 0;
        end
        if (bus.core_en) begin
            en_cnt++;
            en_total++;
        end
        if (running) run_cyc++;
        if (halted && !halted_q) begin
            if (exp_q.size() == 0) begin
                check("unexpected_halt", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("acc_snapshot", acc_snapshot, e.acc);
                check("led_acc", led_acc, e.acc[7:0]);
                check("clk_count", clk_count, e.cnt);
                check("core_en_pulses", en_cnt, e.en);
                check("clear_cycles", clr_len, 1);
                if (e.run_cyc >= 0) check("running_cycles", run_cyc, e.run_cyc);
            end
        end
        halted_q = halted;
    end

    task automatic launch(input logic md);
        exp_q.push_back(model(md));
        @(negedge clk);
        step_mode = md;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("clear_pulse", bus.core_clear, 1);
    endtask

    task automatic wait_halt(input int budget);
        int cyc;
        cyc = 0;
        while (!halted && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        check("halt_reached", halted, 1);
    endtask

    task automatic pulse_step(input int hold, input int gap);
        step = 1'b1;
        repeat (hold) @(negedge clk);
        step = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_core_en"}, bus.core_en, 0);
        check({tag, "_core_clear"}, bus.core_clear, 0);
        check({tag, "_running"}, running, 0);
        check({tag, "_halted"}, halted, 0);
        check({tag, "_clk_count"}, clk_count, 0);
        check({tag, "_acc_snapshot"}, acc_snapshot, 0);
        check({tag, "_led_acc"}, led_acc, 0);
    endtask

    initial begin
        int n;
        int pulses;
        logic md;
        int t0;
        reset     = 1'b1;
        start     = 1'b1;
        step      = 1'b1;
        step_mode = 1'b0;
        clear_prog();
        repeat (3) @(negedge clk);
        check_reset_outputs("in_reset");
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_reset_outputs("held_start");
        end
        start = 1'b0;
        step  = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_no_launch", running, 0);

        // Run mode: LDI 5; ADDI 3; HLT.
        load_directed();
        launch(1'b0);
        wait_halt(50);
        repeat (3) @(negedge clk);

        // Step mode, three pulses spaced five cycles.
        launch(1'b1);
        @(negedge clk);
        t0 = en_total;
        for (int i = 0; i < 3; i++) pulse_step(1, 4);
        check("step_total_en", en_total - t0, 2);
        check("step_halted", halted, 1);
        check("step_clk_count", clk_count, 2);
        check("step_snapshot", acc_snapshot, 16'h0008);

        // Long program saturates the counter; start pulses are ignored.
        load_long();
        launch(1'b0);
        repeat (20) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (60) @(negedge clk);
        start = 1'b1;
        repeat (2) @(negedge clk);
        start = 1'b0;
        check("running_after_start", running, 1);
        wait_halt(600);
        repeat (2) @(negedge clk);

        // Relaunch from HALTED gives the same result.
        load_directed();
        launch(1'b0);
        @(negedge clk);
        check("relaunch_count_zero", clk_count, 0);
        wait_halt(50);
        check("relaunch_snapshot", acc_snapshot, 16'h0008);
        repeat (2) @(negedge clk);

        // Reset in the middle of a run.
        load_long();
        launch(1'b0);
        repeat (3) @(negedge clk);
        check("mid_run_running", running, 1);
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("mid_run_reset");
        reset = 1'b0;
        exp_q.delete();
        repeat (3) @(negedge clk);
        check("post_reset_idle", running, 0);

        // Randomized programs in either mode.
        for (int k = 0; k < 12; k++) begin
            n  = $urandom_range(0, 20);
            md = 1'($urandom_range(0, 1));
            load_random(n);
            launch(md);
            if (md) begin
                @(negedge clk);
                pulses = 0;
                while (!halted && pulses < n + 3) begin
                    pulse_step($urandom_range(1, 3), $urandom_range(1, 4));
                    pulses++;
                end
            end
            wait_halt(100);
            repeat ($urandom_range(1, 4)) @(negedge clk);
        end

        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
